// File: rtl/mem_arbiter_adapter.sv
// Arbitrates icache line reads and dcache line reads/writebacks onto one
// beat-serial physical memory port, assembling or splitting lines per beat.
module mem_arbiter_adapter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [31:0]       pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int BEATS   = LINE_W / BEAT_W;
  localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(BEATS - 1);
  localparam logic [31:0] ADDR_MASK = ~32'((LINE_W / 8) - 1);

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_e;

  state_e              state_q, state_d;
  logic [BEAT_CW-1:0]  beat_q, beat_d;
  logic [31:0]         addr_q, addr_d;
  logic [LINE_W-1:0]   wline_q, wline_d;
  logic [LINE_W-1:0]   i_line_q, i_line_d;
  logic [LINE_W-1:0]   d_line_q, d_line_d;
  logic                last_i_q, last_i_d;
  logic                gnt_i_q, gnt_i_d;

  logic                d_req;
  logic                grant_i;
  logic                i_fire;
  logic                d_fire;
  logic [BEAT_W-1:0]   wbeat [BEATS];

  assign d_req   = d_read | d_write;
  // On contention the side that did not win last time gets the bus.
  assign grant_i = i_read & (~d_req | ~last_i_q);
  assign i_fire  = pmem_resp & (state_q == I_RD);
  assign d_fire  = pmem_resp & (state_q == D_RD);

  // Each read beat lands directly in the requester's line register slice.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      assign i_line_d[gi*BEAT_W +: BEAT_W] = (i_fire && beat_q == BEAT_CW'(gi)) ?
                                             pmem_rdata : i_line_q[gi*BEAT_W +: BEAT_W];
      assign d_line_d[gi*BEAT_W +: BEAT_W] = (d_fire && beat_q == BEAT_CW'(gi)) ?
                                             pmem_rdata : d_line_q[gi*BEAT_W +: BEAT_W];
      assign wbeat[gi] = wline_q[gi*BEAT_W +: BEAT_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      addr_q   <= '0;
      wline_q  <= '0;
      i_line_q <= '0;
      d_line_q <= '0;
      last_i_q <= 1'b1;
      gnt_i_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      addr_q   <= addr_d;
      wline_q  <= wline_d;
      i_line_q <= i_line_d;
      d_line_q <= d_line_d;
      last_i_q <= last_i_d;
      gnt_i_q  <= gnt_i_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    addr_d   = addr_q;
    wline_d  = wline_q;
    last_i_d = last_i_q;
    gnt_i_d  = gnt_i_q;
    case (state_q)
      IDLE: begin
        if (i_read || d_req) begin
          gnt_i_d  = grant_i;
          last_i_d = grant_i;
          beat_d   = '0;
          if (grant_i) begin
            state_d = I_RD;
            addr_d  = i_address & ADDR_MASK;
          end else begin
            addr_d = d_address & ADDR_MASK;
            if (d_write) begin
              state_d = D_WR;
              wline_d = d_wdata;
            end else begin
              state_d = D_RD;
            end
          end
        end
      end
      I_RD, D_RD, D_WR: begin
        if (pmem_resp) begin
          beat_d = beat_q + BEAT_CW'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pmem_address = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    case (state_q)
      I_RD, D_RD: begin
        pmem_read    = 1'b1;
        pmem_address = addr_q;
      end
      D_WR: begin
        pmem_write   = 1'b1;
        pmem_address = addr_q;
        pmem_wdata   = wbeat[beat_q];
      end
      DONE: begin
        i_resp = gnt_i_q;
        d_resp = ~gnt_i_q;
      end
      default: ;
    endcase
  end

  assign i_rdata = i_line_q;
  assign d_rdata = d_line_q;

endmodule

// File: tb/tb_mem_arbiter_adapter.sv
// Directed bench for mem_arbiter_adapter: a transaction-level reference model
// is compared against the DUT every cycle, plus literal checks per scenario.
module tb_mem_arbiter_adapter;
  localparam int LW = 256;
  localparam int BW = 64;

  localparam logic [LW-1:0] LA = {64'h4444444444444444, 64'h3333333333333333,
                                   64'h2222222222222222, 64'h1111111111111111};
  localparam logic [LW-1:0] LB = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC,
                                   64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};
  localparam logic [LW-1:0] LD = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                                   64'h0F0F0F0F0F0F0F0F, 64'hA5A5A5A5A5A5A5A5};
  localparam logic [LW-1:0] LE = {64'h8888888888888888, 64'h7777777777777777,
                                   64'h6666666666666666, 64'h5555555555555555};
  localparam logic [LW-1:0] LC1 = {4{64'h00000000C1C1C1C1}};
  localparam logic [LW-1:0] LC2 = {4{64'h00000000C2C2C2C2}};
  localparam logic [LW-1:0] LC3 = {64'h1, 64'h2, 64'h3, 64'h4};
  localparam logic [LW-1:0] LC4 = {64'h9, 64'h8, 64'h7, 64'h6};

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_read = 1'b0;
  logic [31:0]   i_address = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [31:0]   d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic [31:0]   pmem_address;
  logic          pmem_read;
  logic          pmem_write;
  logic [BW-1:0] pmem_wdata;
  logic [BW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  mem_arbiter_adapter #(.LINE_W(LW), .BEAT_W(BW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_iresp  = 0;
  int n_dresp  = 0;
  bit rd_seen  = 1'b0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Reference model: phase 0 = idle, 1 = burst in flight, 2 = completion cycle.
  int            m_phase;
  int            m_beats;
  bit            m_side_i;
  bit            m_write;
  bit            m_last_i;
  logic [31:0]   m_addr;
  logic [LW-1:0] m_wline, m_iline, m_dline;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0; m_beats = 0; m_side_i = 1'b0; m_write = 1'b0; m_last_i = 1'b1;
      m_addr = '0; m_wline = '0; m_iline = '0; m_dline = '0;
    end else begin
      if (m_phase == 2) begin
        m_phase = 0;
      end else if (m_phase == 1) begin
        if (pmem_resp) begin
          if (!m_write && m_side_i) m_iline[m_beats*BW +: BW] = pmem_rdata;
          if (!m_write && !m_side_i) m_dline[m_beats*BW +: BW] = pmem_rdata;
          m_beats++;
          if (m_beats == LW / BW) m_phase = 2;
        end
      end else if (i_read || d_read || d_write) begin
        if (i_read && (d_read || d_write)) m_side_i = !m_last_i;
        else m_side_i = i_read;
        m_last_i = m_side_i;
        m_write  = !m_side_i && d_write;
        m_addr   = (m_side_i ? i_address : d_address) / 32 * 32;
        m_wline  = d_wdata;
        m_beats  = 0;
        m_phase  = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [BW-1:0] exp_wd;
    exp_wd = (m_phase == 1 && m_write) ? m_wline[m_beats*BW +: BW] : '0;
    chk("pmem_read",    LW'(pmem_read),    LW'(m_phase == 1 && !m_write));
    chk("pmem_write",   LW'(pmem_write),   LW'(m_phase == 1 && m_write));
    chk("pmem_address", LW'(pmem_address), LW'((m_phase == 1) ? m_addr : 32'h0));
    chk("pmem_wdata",   LW'(pmem_wdata),   LW'(exp_wd));
    chk("i_resp",       LW'(i_resp),       LW'(m_phase == 2 && m_side_i));
    chk("d_resp",       LW'(d_resp),       LW'(m_phase == 2 && !m_side_i));
    chk("i_rdata",      i_rdata,           m_iline);
    chk("d_rdata",      d_rdata,           m_dline);
    if (pmem_read) rd_seen = 1'b1;
    if (i_resp) n_iresp++;
    if (d_resp) n_dresp++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Acts as the memory: waits (bounded) for a burst, serves four beats with
  // 'gap' idle cycles before each, and returns in the completion cycle.
  task automatic serve(input logic [LW-1:0] line, input int gap,
                       output logic saw_i, output logic saw_d,
                       output logic [LW-1:0] wcap, output logic [31:0] acap,
                       output int lat);
    lat  = 0;
    wcap = '0;
    while (!(pmem_read || pmem_write) && lat < 20) begin
      tick();
      lat++;
    end
    acap = pmem_address;
    for (int b = 0; b < LW / BW; b++) begin
      for (int g = 0; g < gap; g++) begin
        pmem_resp = 1'b0;
        tick();
      end
      pmem_resp  = 1'b1;
      pmem_rdata = line[b*BW +: BW];
      wcap[b*BW +: BW] = pmem_wdata;
      tick();
    end
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    saw_i = i_resp;
    saw_d = d_resp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          si, sd;
    logic [LW-1:0] wc;
    logic [31:0]   ac;
    int            lat;
    int            snap;

    repeat (3) tick();
    chk("rst_i_rdata",   i_rdata, '0);
    chk("rst_pmem_read", LW'(pmem_read), '0);
    chk("rst_pmem_addr", LW'(pmem_address), '0);
    rst = 1'b1;
    tick();

    i_read = 1'b1; i_address = 32'h0000_0047;
    serve(LA, 0, si, sd, wc, ac, lat);
    chk("A_latency", LW'(lat), LW'(1));
    chk("A_addr",    LW'(ac),  LW'(32'h0000_0040));
    chk("A_iresp",   LW'(si),  LW'(1));
    chk("A_dresp",   LW'(sd),  LW'(0));
    chk("A_rdata",   i_rdata,  LA);
    chk("A_model",   m_iline,  LA);
    $display("txn A icache read addr=%h rdata=%h", ac, i_rdata);
    tick(); i_read = 1'b0;
    chk("A_resp_one_cycle", LW'(i_resp), '0);
    tick();

    rd_seen = 1'b0;
    d_write = 1'b1; d_address = 32'h0000_1010; d_wdata = LB;
    serve('0, 0, si, sd, wc, ac, lat);
    chk("B_wbeats", wc, LB);
    chk("B_dresp",  LW'(sd), LW'(1));
    chk("B_iresp",  LW'(si), LW'(0));
    chk("B_addr",   LW'(ac), LW'(32'h0000_1000));
    $display("txn B dcache write addr=%h wbeats=%h", ac, wc);
    tick(); d_write = 1'b0;
    tick();
    chk("B_no_read", LW'(rd_seen), '0);

    d_read = 1'b1; d_address = 32'h1234_5678;
    serve(LD, 2, si, sd, wc, ac, lat);
    chk("D_latency", LW'(lat), LW'(1));
    chk("D_addr",    LW'(ac),  LW'(32'h1234_5660));
    chk("D_dresp",   LW'(sd),  LW'(1));
    chk("D_rdata",   d_rdata,  LD);
    $display("txn D dcache read with gaps addr=%h rdata=%h", ac, d_rdata);
    tick(); d_read = 1'b0;
    tick();

    d_read = 1'b1; d_address = 32'h0000_0300;
    tick();
    pmem_resp = 1'b1; pmem_rdata = 64'h5555555555555555;
    tick();
    pmem_rdata = 64'h6666666666666666;
    tick();
    snap = n_dresp;
    rst = 1'b0; pmem_resp = 1'b0; d_read = 1'b0;
    #1;
    chk("E_read_drop",  LW'(pmem_read), '0);
    chk("E_rdata_clr",  d_rdata, '0);
    repeat (2) tick();
    chk("E_no_dresp",   LW'(n_dresp), LW'(snap));
    $display("txn E dcache read abandoned by reset");
    rst = 1'b1;
    tick();
    i_read = 1'b1; i_address = 32'h0000_0400;
    serve(LE, 0, si, sd, wc, ac, lat);
    chk("E_iresp",  LW'(si), LW'(1));
    chk("E_rdata",  i_rdata, LE);
    $display("txn E icache read after reset rdata=%h", i_rdata);
    tick(); i_read = 1'b0;
    tick();

    i_read = 1'b1; d_read = 1'b1; i_address = 32'h0000_0500; d_address = 32'h0000_0600;
    serve(LC1, 0, si, sd, wc, ac, lat);
    chk("C1_dresp", LW'(sd), LW'(1));
    chk("C1_addr",  LW'(ac), LW'(32'h0000_0600));
    $display("txn C1 contention granted addr=%h", ac);
    tick(); d_read = 1'b0;
    serve(LC2, 0, si, sd, wc, ac, lat);
    chk("C2_iresp", LW'(si), LW'(1));
    chk("C2_addr",  LW'(ac), LW'(32'h0000_0500));
    $display("txn C2 granted addr=%h", ac);
    tick(); i_read = 1'b0;
    tick();
    i_read = 1'b1; d_read = 1'b1;
    serve(LC3, 1, si, sd, wc, ac, lat);
    chk("C3_dresp", LW'(sd), LW'(1));
    chk("C3_rdata", d_rdata, LC3);
    $display("txn C3 contention granted addr=%h", ac);
    tick(); d_read = 1'b0;
    serve(LC4, 0, si, sd, wc, ac, lat);
    chk("C4_iresp", LW'(si), LW'(1));
    chk("C4_rdata", i_rdata, LC4);
    $display("txn C4 granted addr=%h", ac);
    tick(); i_read = 1'b0;
    tick();

    snap = n_iresp + n_dresp;
    pmem_resp = 1'b1; pmem_rdata = '1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("F_idle_read",  LW'(pmem_read),  '0);
      chk("F_idle_write", LW'(pmem_write), '0);
    end
    pmem_resp = 1'b0; pmem_rdata = '0;
    tick();
    chk("F_no_resp", LW'(n_iresp + n_dresp), LW'(snap));
    chk("F_i_hold",  i_rdata, LC4);
    $display("txn F pmem_resp while idle ignored");

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_adapter.md
MEM_ARBITER_ADAPTER -- requirements
Module: mem_arbiter_adapter

Interface
REQ-001 SHALL have parameter LINE_W, default 256, cache line width in bits.
REQ-002 SHALL have parameter BEAT_W, default 64, physical memory beat width; BEATS = LINE_W/BEAT_W = 4.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port i_read  input  1  icache line read request.
REQ-006 SHALL have port i_address  input  32  icache line address.
REQ-007 SHALL have port i_rdata  output  LINE_W  assembled icache line.
REQ-008 SHALL have port i_resp  output  1  icache transaction complete.
REQ-009 SHALL have port d_read  input  1  dcache line read request.
REQ-010 SHALL have port d_write  input  1  dcache line writeback request.
REQ-011 SHALL have port d_address  input  32  dcache line address.
REQ-012 SHALL have port d_wdata  input  LINE_W  dcache writeback line.
REQ-013 SHALL have port d_rdata  output  LINE_W  assembled dcache line.
REQ-014 SHALL have port d_resp  output  1  dcache transaction complete.
REQ-015 SHALL have port pmem_address  output  32  burst base address.
REQ-016 SHALL have port pmem_read  output  1  burst read request.
REQ-017 SHALL have port pmem_write  output  1  burst write request.
REQ-018 SHALL have port pmem_wdata  output  BEAT_W  current write beat.
REQ-019 SHALL have port pmem_rdata  input  BEAT_W  current read beat.
REQ-020 SHALL have port pmem_resp  input  1  beat accepted/valid.

Function
REQ-021 SHALL implement states IDLE, I_RD, D_RD, D_WR, DONE.
REQ-022 IDLE: no request -> stay; otherwise grant per REQ-023/024, latch address (bits [4:0] forced 0) and, for D_WR, d_wdata; clear beat counter.
REQ-023 Dcache request: d_write takes precedence over d_read when both asserted.
REQ-024 Icache and dcache both pending: grant the side not granted last (round-robin, 1-bit last-grant flag; reset value grants dcache first).
REQ-025 I_RD/D_RD: pmem_read=1 held continuously; each cycle with pmem_resp=1 stores pmem_rdata into line slice [BEAT_W*beat +: BEAT_W], beat 0 = bits [63:0].
REQ-026 D_WR: pmem_write=1 held; pmem_wdata = latched line slice for current beat; pmem_resp=1 advances beat.
REQ-027 2-bit beat counter; pmem_resp on beat 3 -> counter wraps to 0, state -> DONE, pmem_read/pmem_write deassert next cycle.
REQ-028 pmem_resp=0 mid-burst: hold state, beat, outputs (stall-tolerant).
REQ-029 DONE: exactly one cycle; i_resp=1 if granted side was icache, else d_resp=1; then -> IDLE.
REQ-030 i_rdata/d_rdata SHALL be registered, valid during DONE, stable until the next read on that side completes its first beat.
REQ-031 pmem_address SHALL equal latched line address throughout the burst; 0 in IDLE.
REQ-032 pmem_resp in IDLE or DONE SHALL be ignored.
REQ-033 Requesters drop requests the cycle after their resp; request seen again in IDLE starts a new transaction.
REQ-034 Latency: request in IDLE cycle t -> pmem_read/write at t+1; with pmem_resp at t+1..t+4, resp at t+5.
REQ-035 pmem_read and pmem_write SHALL never be asserted together.

Reset
REQ-036 rst=0 SHALL asynchronously force IDLE, beat=0, last-grant=icache, all outputs 0, line registers 0.
REQ-037 Reset mid-burst SHALL abandon the burst without any resp; operation resumes from IDLE on rst=1.

Verification
REQ-038 i_read, addr 0x0000_0047, beats 0x11..,0x22..,0x33..,0x44.. back-to-back -> pmem_address 0x0000_0040, i_rdata={0x44..,0x33..,0x22..,0x11..}, i_resp one cycle at t+5.
REQ-039 d_write, d_wdata=0xDDDD..CCCC..BBBB..AAAA -> pmem_wdata AAAA.., BBBB.., CCCC.., DDDD.. on successive resp beats, d_resp once, pmem_read never high.
REQ-040 i_read and d_read same cycle, twice in succession -> first dcache, then icache; simultaneous again -> dcache.
REQ-041 d_read with 2-cycle pmem_resp gaps between beats -> correct d_rdata, state/outputs held during gaps, d_resp after beat 3.
REQ-042 rst=0 after beat 1 of d_read -> pmem_read=0 immediately, no d_resp; new i_read after release completes normally.
REQ-043 pmem_resp pulsed while IDLE -> no state change, no resp.
